// File: rtl/fizzle_writer.sv
// Fizzlefade framebuffer writer.
// After an accepted start and a programmable number of frame strobes, writes one
// colour index to every framebuffer pixel exactly once. The order comes from a
// maximal-length Fibonacci LFSR, and the writes come at a programmable rate.
// Address 0 is never produced by the LFSR, so it is written last in its own state.
//
// Request semantics: start is a single-cycle request with no ready/ack. It is
// accepted only in IDLE or DONE, and the accept is visible as busy rising on the
// following cycle. A start while busy is dropped. frame_sys is a single-cycle strobe
// that counts only in WAIT. fb_we is a single-cycle write qualifier, and
// fb_addr_write/fb_colr_write are valid in the same cycle. There is no back-pressure.
module fizzle_writer #(
   parameter int unsigned         FB_WIDTH    = 160,
   parameter int unsigned         FB_HEIGHT   = 120,
   parameter int unsigned         CIDXW       = 4,
   parameter int unsigned         LFSR_LEN    = 15,
   parameter logic [LFSR_LEN-1:0] TAPS        = 15'b110000000000000,
   parameter int unsigned         SEED        = 1,
   parameter int unsigned         WAIT_FRAMES = 300,
   parameter int unsigned         RATE_CYC    = 10000
) (
   input  logic                                   clk_sys,
   input  logic                                   rst_sys_n,
   input  logic                                   start,
   input  logic                                   frame_sys,
   input  logic [CIDXW-1:0]                       colr_in,
   output logic                                   fb_we,
   output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]  fb_addr_write,
   output logic [CIDXW-1:0]                       fb_colr_write,
   output logic                                   busy,
   output logic                                   done,
   output logic [2:0]                             state_o
);

   localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
   localparam int unsigned ADDR_W    = $clog2(FB_PIXELS);
   localparam int unsigned RATE_W    = (RATE_CYC > 1) ? $clog2(RATE_CYC) : 1;
   localparam int unsigned WAIT_W    = (WAIT_FRAMES > 0) ? $clog2(WAIT_FRAMES + 1) : 1;

   localparam logic [LFSR_LEN-1:0] SEED_V    = LFSR_LEN'(SEED);
   // One bit wider than the LFSR so a framebuffer that fills the whole LFSR
   // range still compares correctly.
   localparam logic [LFSR_LEN:0]   PIX_LIMIT = (LFSR_LEN + 1)'(FB_PIXELS);
   localparam logic [RATE_W-1:0]   RATE_LAST = RATE_W'(RATE_CYC - 1);
   localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(WAIT_FRAMES - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_FADE = 3'd2,
      S_LAST = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              state_q,    state_d;
   logic [LFSR_LEN-1:0] lfsr_q,     lfsr_d;
   logic [RATE_W-1:0]   cnt_rate_q, cnt_rate_d;
   logic [WAIT_W-1:0]   cnt_wait_q, cnt_wait_d;
   logic [CIDXW-1:0]    colr_q,     colr_d;
   logic                we_q,       we_d;
   logic [ADDR_W-1:0]   addr_q,     addr_d;

   logic                lfsr_fb;
   logic [LFSR_LEN-1:0] lfsr_step;
   logic                lfsr_in_range;
   logic                rate_tick;

   // Next LFSR value: the parity of the tapped stages shifts in at bit 0.
   always_comb begin
      lfsr_fb   = ^(lfsr_q & TAPS);
      lfsr_step = {lfsr_q[LFSR_LEN-2:0], lfsr_fb};
   end

   // Pixel-address qualification and rate tick.
   always_comb begin
      lfsr_in_range = ({1'b0, lfsr_q} < PIX_LIMIT);
      rate_tick     = (cnt_rate_q == RATE_LAST);
   end

   // State, counters and registered write port.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state_q    <= S_IDLE;
         lfsr_q     <= SEED_V;
         cnt_rate_q <= '0;
         cnt_wait_q <= '0;
         colr_q     <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         cnt_rate_q <= cnt_rate_d;
         cnt_wait_q <= cnt_wait_d;
         colr_q     <= colr_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
      end
   end

   // Next-state and write decisions.
   // A skipped out-of-range value keeps cnt_rate at its tick value, so the
   // following value is tried on the very next cycle. The same rule carries
   // into LAST, which keeps the spacing of the final address-0 write consistent
   // with every other write.
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      cnt_rate_d = cnt_rate_q;
      cnt_wait_d = cnt_wait_q;
      colr_d     = colr_q;
      we_d       = 1'b0;
      addr_d     = addr_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               colr_d     = colr_in;
               lfsr_d     = SEED_V;
               cnt_rate_d = '0;
               cnt_wait_d = '0;
               state_d    = (WAIT_FRAMES == 0) ? S_FADE : S_WAIT;
            end
         end

         S_WAIT: begin
            if (frame_sys) begin
               cnt_wait_d = cnt_wait_q + WAIT_W'(1);
               if (cnt_wait_q == WAIT_LAST) begin
                  state_d = S_FADE;
               end
            end
         end

         S_FADE: begin
            if (rate_tick) begin
               lfsr_d = lfsr_step;
               if (lfsr_in_range) begin
                  we_d       = 1'b1;
                  addr_d     = lfsr_q[ADDR_W-1:0];
                  cnt_rate_d = '0;
               end
               if (lfsr_step == SEED_V) begin
                  state_d = S_LAST;
               end
            end else begin
               cnt_rate_d = cnt_rate_q + RATE_W'(1);
            end
         end

         S_LAST: begin
            if (rate_tick) begin
               we_d       = 1'b1;
               addr_d     = '0;
               cnt_rate_d = '0;
               state_d    = S_DONE;
            end else begin
               cnt_rate_d = cnt_rate_q + RATE_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign fb_we         = we_q;
   assign fb_addr_write = addr_q;
   assign fb_colr_write = colr_q;
   assign busy          = (state_q == S_WAIT) || (state_q == S_FADE) || (state_q == S_LAST);
   assign done          = (state_q == S_DONE);
   assign state_o       = state_q;

endmodule
